axi_wr_arb2: RTL and testbench

Two-master write-channel arbiter for the 32-bit AXI write path (AW/W/B channels with 4-bit IDs, 4-bit AWLEN, WID and WSTRB). It shares one downstream write slave port between masters m0 and m1. It grants one whole burst at a time with round-robin fairness, generates the downstream WLAST from its own beat counter, and routes the B response back to the owning master. Read channels do not pass through this block.

---
 rtl/axi_wr_arb2_if.sv | 45 ++++
 rtl/axi_wr_arb2.sv | 156 +++++++++++++++
 tb/tb_axi_wr_arb2.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_arb2_if.sv
// AXI write-channel bundle (AW/W/B) shared by
// both upstream masters and the downstream slave.
interface axi_wr_arb2_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              awvalid;
  logic              awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;

  modport master (
    output awvalid, awid, awaddr, awlen,
    output awsize, awburst,
    output wvalid, wid, wdata, wstrb, wlast,
    output bready,
    input  awready, wready,
    input  bvalid, bid, bresp
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen,
    input  awsize, awburst,
    input  wvalid, wid, wdata, wstrb, wlast,
    input  bready,
    output awready, wready,
    output bvalid, bid, bresp
  );
endinterface

// File: rtl/axi_wr_arb2.sv
// Two-master AXI write arbiter: one burst at a
// time, round-robin, locally generated WLAST.
module axi_wr_arb2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic          clk,
  input  logic          rst,
  axi_wr_arb2_if.slave  m0,
  axi_wr_arb2_if.slave  m1,
  axi_wr_arb2_if.master s,
  output logic          grant,
  output logic          busy,
  output logic          err_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;
  logic [3:0]      len_q, len_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [3:0]      beat_q, beat_d;

  logic aw_go, w_go, b_go;
  logic wlast_c;

  logic              awvalid_g;
  logic [ID_W-1:0]   awid_g;
  logic [ADDR_W-1:0] awaddr_g;
  logic [3:0]        awlen_g;
  logic                wvalid_g;
  logic [ID_W-1:0]     wid_g;
  logic [DATA_W-1:0]   wdata_g;
  logic [DATA_W/8-1:0] wstrb_g;
  logic                wlast_g;
  logic                bready_g;

  assign awvalid_g = grant_q ? m1.awvalid : m0.awvalid;
  assign awid_g    = grant_q ? m1.awid    : m0.awid;
  assign awaddr_g  = grant_q ? m1.awaddr  : m0.awaddr;
  assign awlen_g   = grant_q ? m1.awlen   : m0.awlen;
  assign wvalid_g  = grant_q ? m1.wvalid  : m0.wvalid;
  assign wid_g     = grant_q ? m1.wid     : m0.wid;
  assign wdata_g   = grant_q ? m1.wdata   : m0.wdata;
  assign wstrb_g   = grant_q ? m1.wstrb   : m0.wstrb;
  assign wlast_g   = grant_q ? m1.wlast   : m0.wlast;
  assign bready_g  = grant_q ? m1.bready  : m0.bready;

  assign wlast_c = (beat_q == len_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      len_q   <= '0;
      id_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      len_q   <= len_d;
      id_q    <= id_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    len_d     = len_q;
    id_d      = id_q;
    beat_d    = beat_q;
    aw_go     = 1'b0;
    w_go      = 1'b0;
    b_go      = 1'b0;
    err_pulse = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0.awvalid || m1.awvalid) begin
          state_d = ADDR;
          // Tie goes to whoever did not win last
          grant_d = (m0.awvalid && m1.awvalid)
                  ? ~last_q : m1.awvalid;
        end
      end
      ADDR: begin
        aw_go = 1'b1;
        if (awvalid_g && s.awready) begin
          len_d   = awlen_g;
          id_d    = awid_g;
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        w_go = 1'b1;
        if (wvalid_g && s.wready) begin
          beat_d    = beat_q + 4'd1;
          err_pulse = (wid_g != id_q)
                    || (wlast_g != wlast_c);
          if (wlast_c) state_d = RESP;
        end
      end
      RESP: begin
        b_go = 1'b1;
        if (s.bvalid && bready_g) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s.awvalid = aw_go & awvalid_g;
  assign s.awid    = awid_g;
  assign s.awaddr  = awaddr_g;
  assign s.awlen   = awlen_g;
  assign s.awsize  = grant_q ? m1.awsize : m0.awsize;
  assign s.awburst = grant_q ? m1.awburst
                             : m0.awburst;

  assign s.wvalid = w_go & wvalid_g;
  assign s.wid    = wid_g;
  assign s.wdata  = wdata_g;
  assign s.wstrb  = wstrb_g;
  assign s.wlast  = wlast_c;

  assign s.bready = b_go & bready_g;

  assign m0.awready = aw_go & ~grant_q & s.awready;
  assign m1.awready = aw_go &  grant_q & s.awready;
  assign m0.wready  = w_go  & ~grant_q & s.wready;
  assign m1.wready  = w_go  &  grant_q & s.wready;
  assign m0.bvalid  = b_go  & ~grant_q & s.bvalid;
  assign m1.bvalid  = b_go  &  grant_q & s.bvalid;
  assign m0.bid     = s.bid;
  assign m1.bid     = s.bid;
  assign m0.bresp   = s.bresp;
  assign m1.bresp   = s.bresp;

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_axi_wr_arb2.sv
// Directed bench for axi_wr_arb2: arbitration,
// WLAST generation, errors, reset, backpressure.
module tb_axi_wr_arb2;

  logic clk;
  logic rst;
  logic grant;
  logic busy;
  logic err_pulse;

  int vectors;
  int miscompares;

  logic [31:0] wq[$];

  axi_wr_arb2_if m0_if ();
  axi_wr_arb2_if m1_if ();
  axi_wr_arb2_if s_if ();

  axi_wr_arb2 dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if.slave),
    .m1        (m1_if.slave),
    .s         (s_if.master),
    .grant     (grant),
    .busy      (busy),
    .err_pulse (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (s_if.wvalid && s_if.wready)
      wq.push_back(s_if.wdata);

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_aw(input int m, input logic v,
                        input logic [3:0] id,
                        input logic [31:0] a,
                        input logic [3:0] l);
    if (m == 0) begin
      m0_if.awvalid = v; m0_if.awid = id;
      m0_if.awaddr = a; m0_if.awlen = l;
    end else begin
      m1_if.awvalid = v; m1_if.awid = id;
      m1_if.awaddr = a; m1_if.awlen = l;
    end
  endtask

  task automatic set_w(input int m, input logic v,
                       input logic [3:0] id,
                       input logic [31:0] d,
                       input logic l);
    if (m == 0) begin
      m0_if.wvalid = v; m0_if.wid = id;
      m0_if.wdata = d; m0_if.wlast = l;
    end else begin
      m1_if.wvalid = v; m1_if.wid = id;
      m1_if.wdata = d; m1_if.wlast = l;
    end
  endtask

  task automatic set_br(input int m, input logic v);
    if (m == 0) m0_if.bready = v;
    else        m1_if.bready = v;
  endtask

  function automatic logic awrdy(input int m);
    return (m == 1) ? m1_if.awready : m0_if.awready;
  endfunction

  function automatic logic wrdy(input int m);
    return (m == 1) ? m1_if.wready : m0_if.wready;
  endfunction

  function automatic logic bvld(input int m);
    return (m == 1) ? m1_if.bvalid : m0_if.bvalid;
  endfunction

  function automatic logic [3:0] bidm(input int m);
    return (m == 1) ? m1_if.bid : m0_if.bid;
  endfunction

  function automatic logic [1:0] brsp(input int m);
    return (m == 1) ? m1_if.bresp : m0_if.bresp;
  endfunction

  task automatic run_burst(input int m,
                           input logic [3:0] id,
                           input logic [3:0] len,
                           input int bad,
                           input logic [31:0] base,
                           input bit bp,
                           input bit both);
    int o;
    int n;
    o = 1 - m;
    n = int'(len) + 1;
    wq.delete();
    set_aw(m, 1'b1, id, base, len);
    if (both)
      set_aw(o, 1'b1, id ^ 4'h5, base ^ 32'h1000, len);
    #1;
    chk("idle_s_awvalid", s_if.awvalid, 0);
    chk("idle_busy", busy, 0);
    tick;
    chk("addr_s_awvalid", s_if.awvalid, 1);
    chk("addr_grant", grant, m);
    chk("addr_busy", busy, 1);
    chk("addr_awready_own", awrdy(m), 1);
    chk("addr_awready_other", awrdy(o), 0);
    chk("addr_awaddr", s_if.awaddr, base);
    chk("addr_awlen", s_if.awlen, len);
    chk("addr_awid", s_if.awid, id);
    tick;
    set_aw(m, 1'b0, id, base, len);
    for (int b = 0; b < n; b++) begin
      set_w(m, 1'b1, (b == bad) ? ~id : id,
            base + b, b == n - 1);
      if (bp) begin
        s_if.wready = 1'b0;
        #1;
        chk("bp_wready", wrdy(m), 0);
        chk("bp_s_wvalid", s_if.wvalid, 1);
        tick;
        s_if.wready = 1'b1;
      end
      #1;
      chk("w_data", s_if.wdata, base + b);
      chk("w_last", s_if.wlast, b == n - 1);
      chk("w_err", err_pulse, b == bad);
      chk("w_wready_own", wrdy(m), 1);
      chk("w_wready_other", wrdy(o), 0);
      tick;
    end
    set_w(m, 1'b1, id, 32'hdead_beef, 1'b0);
    #1;
    chk("resp_s_wvalid", s_if.wvalid, 0);
    chk("resp_wready", wrdy(m), 0);
    set_w(m, 1'b0, id, 32'h0, 1'b0);
    s_if.bvalid = 1'b1;
    s_if.bid    = id;
    s_if.bresp  = 2'b00;
    if (bp) begin
      set_br(m, 1'b0);
      #1;
      chk("bp_bvalid", bvld(m), 1);
      chk("bp_s_bready", s_if.bready, 0);
      tick;
    end
    set_br(m, 1'b1);
    #1;
    chk("b_bvalid_own", bvld(m), 1);
    chk("b_bvalid_other", bvld(o), 0);
    chk("b_bid", bidm(m), id);
    chk("b_bresp", brsp(m), 2'b00);
    chk("b_s_bready", s_if.bready, 1);
    chk("b_busy", busy, 1);
    tick;
    s_if.bvalid = 1'b0;
    set_br(m, 1'b0);
    #1;
    chk("post_busy", busy, 0);
    chk("beat_count", wq.size(), n);
    for (int i = 0; i < n; i++)
      if (i < wq.size())
        chk("beat_order", wq[i], base + i);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b0;
    set_aw(0, 1'b0, 4'h0, 32'h0, 4'h0);
    set_aw(1, 1'b0, 4'h0, 32'h0, 4'h0);
    set_w(0, 1'b0, 4'h0, 32'h0, 1'b0);
    set_w(1, 1'b0, 4'h0, 32'h0, 1'b0);
    m0_if.awsize = 3'd2; m0_if.awburst = 2'd1;
    m1_if.awsize = 3'd2; m1_if.awburst = 2'd1;
    m0_if.wstrb = 4'hf; m1_if.wstrb = 4'hf;
    m0_if.bready = 1'b0; m1_if.bready = 1'b0;
    s_if.awready = 1'b1;
    s_if.wready  = 1'b1;
    s_if.bvalid  = 1'b0;
    s_if.bid     = 4'h0;
    s_if.bresp   = 2'b00;
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_s_awvalid", s_if.awvalid, 0);
    chk("rst_s_wvalid", s_if.wvalid, 0);
    chk("rst_s_bready", s_if.bready, 0);
    chk("rst_m0_awready", m0_if.awready, 0);
    chk("rst_err", err_pulse, 0);
    rst = 1'b1;
    tick;

    // Simultaneous requests: 0, 1, 0
    run_burst(0, 4'h1, 4'd1, -1, 32'h1000, 0, 1);
    run_burst(1, 4'h2, 4'd0, -1, 32'h2000, 0, 1);
    run_burst(0, 4'h3, 4'd2, -1, 32'h3000, 0, 1);
    set_aw(1, 1'b0, 4'h0, 32'h0, 4'h0);
    tick;

    run_burst(0, 4'h4, 4'd3, -1, 32'h4000, 0, 0);
    run_burst(1, 4'h5, 4'd0, -1, 32'h4100, 0, 0);
    run_burst(0, 4'h6, 4'd15, -1, 32'h4200, 0, 0);
    run_burst(1, 4'h7, 4'd3, 1, 32'h4300, 0, 0);
    run_burst(0, 4'h8, 4'd5, -1, 32'h4400, 1, 0);

    // Reset in DATA after the first of four beats
    set_aw(0, 1'b1, 4'h2, 32'h5000, 4'd3);
    tick;
    tick;
    set_aw(0, 1'b0, 4'h2, 32'h5000, 4'd3);
    set_w(0, 1'b1, 4'h2, 32'h5000, 1'b0);
    tick;
    set_w(0, 1'b1, 4'h2, 32'h5001, 1'b0);
    #1;
    chk("pre_rst_s_wvalid", s_if.wvalid, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_s_wvalid", s_if.wvalid, 0);
    chk("mid_rst_wready", m0_if.wready, 0);
    chk("mid_rst_s_awvalid", s_if.awvalid, 0);
    chk("mid_rst_s_bready", s_if.bready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_err", err_pulse, 0);
    set_w(0, 1'b0, 4'h0, 32'h0, 1'b0);
    #1;
    rst = 1'b1;
    tick;
    run_burst(1, 4'h9, 4'd2, -1, 32'h6000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
